id_hazard_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the decode stage. It generalises fixed EXE/MEM/WB bypassing to NUM_FWD priority-ordered forwarding channels. It adds per-register pending-write counters, so hazards are still detected when a producer sits in a non-forwarding stage such as a multi-cycle divider. It supplies forwarded rj/rkd operand values and the ID ready_go, and keeps a stall performance counter plus a sticky underflow error flag.

---
 rtl/id_hazard_scoreboard_pkg.sv | 13 +
 rtl/id_hazard_scoreboard_fwd_select.sv | 42 ++++
 rtl/id_hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants and channel-slice helper for the decode-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;
    localparam int AW          = 5;
    localparam int DW          = 32;
    localparam int NREG        = 2 ** AW;
    localparam int NUM_FWD_DEF = 3;
    localparam int CNT_W_DEF   = 2;

    // Low bit of channel ch inside a flattened bus of w-bit lanes.
    function automatic int ch_lo(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/id_hazard_scoreboard_fwd_select.sv
// Priority forwarding match and mux for one decode operand; produces the value and a hazard flag.
module id_hazard_scoreboard_fwd_select #(
    parameter int NUM_FWD = id_hazard_scoreboard_pkg::NUM_FWD_DEF,
    parameter int AW      = id_hazard_scoreboard_pkg::AW,
    parameter int DW      = id_hazard_scoreboard_pkg::DW
) (
    input  logic [AW-1:0]         addr,
    input  logic                  en,
    input  logic [DW-1:0]         rf_rdata,
    input  logic                  pend_nz,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD*AW-1:0] fwd_dest,
    input  logic [NUM_FWD-1:0]    fwd_data_ok,
    input  logic [NUM_FWD*DW-1:0] fwd_data,
    output logic [DW-1:0]         value,
    output logic                  hazard
);
    import id_hazard_scoreboard_pkg::*;

    logic found;

    always_comb begin
        value  = rf_rdata;
        hazard = 1'b0;
        found  = 1'b0;
        if (en && addr != '0) begin
            // Channel 0 is the youngest producer, so the first match wins.
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!found && fwd_valid[i] && fwd_dest[ch_lo(i, AW) +: AW] == addr) begin
                    found  = 1'b1;
                    value  = fwd_data[ch_lo(i, DW) +: DW];
                    hazard = !fwd_data_ok[i];
                end
            end
            if (!found) begin
                hazard = pend_nz;
            end
        end else begin
            value = '0;
        end
    end
endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage operand forwarding and hazard unit with per-register pending-write counters.
module id_hazard_scoreboard #(
    parameter int NUM_FWD = id_hazard_scoreboard_pkg::NUM_FWD_DEF,
    parameter int AW      = id_hazard_scoreboard_pkg::AW,
    parameter int DW      = id_hazard_scoreboard_pkg::DW,
    parameter int CNT_W   = id_hazard_scoreboard_pkg::CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rj,
    input  logic                  id_rj_en,
    input  logic [AW-1:0]         id_rkd,
    input  logic                  id_rkd_en,
    input  logic [AW-1:0]         id_dest,
    input  logic                  id_gr_we,
    input  logic                  id_issue,
    input  logic [DW-1:0]         rf_rdata1,
    input  logic [DW-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD*AW-1:0] fwd_dest,
    input  logic [NUM_FWD-1:0]    fwd_data_ok,
    input  logic [NUM_FWD*DW-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]    fwd_cancel,
    input  logic                  retire_we,
    input  logic [AW-1:0]         retire_dest,
    output logic [DW-1:0]         rj_value,
    output logic [DW-1:0]         rkd_value,
    output logic                  ready_go,
    output logic                  pend_full,
    output logic [31:0]           stall_cnt,
    output logic                  err_underflow
);
    import id_hazard_scoreboard_pkg::*;

    localparam int               NUM_REG = 1 << AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pending    [NUM_REG];
    logic [CNT_W-1:0] pending_nx [NUM_REG];
    logic             uflow;
    int               net;
    logic             hazard_rj;
    logic             hazard_rkd;

    id_hazard_scoreboard_fwd_select #(.NUM_FWD(NUM_FWD), .AW(AW), .DW(DW)) u_sel_rj (
        .addr        (id_rj),
        .en          (id_rj_en),
        .rf_rdata    (rf_rdata1),
        .pend_nz     (pending[id_rj] != '0),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data_ok (fwd_data_ok),
        .fwd_data    (fwd_data),
        .value       (rj_value),
        .hazard      (hazard_rj)
    );

    id_hazard_scoreboard_fwd_select #(.NUM_FWD(NUM_FWD), .AW(AW), .DW(DW)) u_sel_rkd (
        .addr        (id_rkd),
        .en          (id_rkd_en),
        .rf_rdata    (rf_rdata2),
        .pend_nz     (pending[id_rkd] != '0),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data_ok (fwd_data_ok),
        .fwd_data    (fwd_data),
        .value       (rkd_value),
        .hazard      (hazard_rkd)
    );

    assign pend_full = id_gr_we && (id_dest != '0) && (pending[id_dest] == CNT_MAX);
    assign ready_go  = !hazard_rj && !hazard_rkd && !pend_full;

    // Net all same-cycle events per register, then clamp: below zero is an error, above max saturates.
    always_comb begin
        uflow         = 1'b0;
        net           = 0;
        pending_nx[0] = '0;
        for (int r = 1; r < NUM_REG; r++) begin
            net = int'(pending[r]);
            if (id_issue && id_gr_we && id_dest == AW'(r)) begin
                net = net + 1;
            end
            if (retire_we && retire_dest == AW'(r)) begin
                net = net - 1;
            end
            for (int i = 0; i < NUM_FWD; i++) begin
                if (fwd_cancel[i] && fwd_valid[i] && fwd_dest[ch_lo(i, AW) +: AW] == AW'(r)) begin
                    net = net - 1;
                end
            end
            if (net < 0) begin
                pending_nx[r] = '0;
                uflow         = 1'b1;
            end else if (net > int'(CNT_MAX)) begin
                pending_nx[r] = CNT_MAX;
            end else begin
                pending_nx[r] = CNT_W'(net);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REG; r++) begin
                pending[r] <= '0;
            end
            stall_cnt     <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REG; r++) begin
                pending[r] <= pending_nx[r];
            end
            if (id_valid && !ready_go) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (uflow) begin
                err_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed scenarios plus randomized traffic against a reference model.
module tb_id_hazard_scoreboard;
    localparam int NUM_FWD = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int CNT_W   = 2;
    localparam int NREG    = 1 << AW;
    localparam int PMAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  id_valid, id_rj_en, id_rkd_en, id_gr_we, id_issue, retire_we;
    logic [AW-1:0]         id_rj, id_rkd, id_dest, retire_dest;
    logic [DW-1:0]         rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]    fwd_valid, fwd_data_ok, fwd_cancel;
    logic [NUM_FWD*AW-1:0] fwd_dest;
    logic [NUM_FWD*DW-1:0] fwd_data;
    logic [DW-1:0]         rj_value, rkd_value;
    logic                  ready_go, pend_full, err_underflow;
    logic [31:0]           stall_cnt;

    int          checks = 0;
    int          failures = 0;
    int          m_pend [NREG];
    logic [31:0] m_stall;
    bit          m_err;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.NUM_FWD(NUM_FWD), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rj(id_rj), .id_rj_en(id_rj_en),
        .id_rkd(id_rkd), .id_rkd_en(id_rkd_en), .id_dest(id_dest), .id_gr_we(id_gr_we),
        .id_issue(id_issue), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data_ok(fwd_data_ok),
        .fwd_data(fwd_data), .fwd_cancel(fwd_cancel), .retire_we(retire_we),
        .retire_dest(retire_dest), .rj_value(rj_value), .rkd_value(rkd_value),
        .ready_go(ready_go), .pend_full(pend_full), .stall_cnt(stall_cnt),
        .err_underflow(err_underflow)
    );

    // Reference model: operand lookup from the resolution rules.
    function automatic void m_resolve(input logic [AW-1:0] a, input logic en, input logic [DW-1:0] rf,
                                      output logic [DW-1:0] v, output bit hz);
        v  = rf;
        hz = 1'b0;
        if (!en || a == '0) begin
            v = '0;
            return;
        end
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwd_valid[i] && fwd_dest[i*AW +: AW] == a) begin
                v  = fwd_data[i*DW +: DW];
                hz = !fwd_data_ok[i];
                return;
            end
        end
        hz = (m_pend[a] != 0);
    endfunction

    function automatic bit m_full();
        return id_gr_we && id_dest != '0 && m_pend[id_dest] == PMAX;
    endfunction

    function automatic bit m_ready();
        logic [DW-1:0] v;
        bit h1, h2;
        m_resolve(id_rj, id_rj_en, rf_rdata1, v, h1);
        m_resolve(id_rkd, id_rkd_en, rf_rdata2, v, h2);
        return !h1 && !h2 && !m_full();
    endfunction

    // One clock: model next state from current inputs, then advance to just after the edge.
    task automatic tick();
        int nx [NREG];
        bit uf;
        bit rdy;
        rdy = m_ready();
        uf  = 1'b0;
        nx[0] = 0;
        for (int r = 1; r < NREG; r++) begin
            int n;
            n = m_pend[r];
            if (id_issue && id_gr_we && id_dest == r) n++;
            if (retire_we && retire_dest == r) n--;
            for (int i = 0; i < NUM_FWD; i++)
                if (fwd_cancel[i] && fwd_valid[i] && fwd_dest[i*AW +: AW] == r) n--;
            if (n < 0) begin
                n  = 0;
                uf = 1'b1;
            end
            if (n > PMAX) n = PMAX;
            nx[r] = n;
        end
        @(posedge clk);
        #1;
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            m_stall = 0;
            m_err   = 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) m_pend[r] = nx[r];
            if (id_valid && !rdy) m_stall = m_stall + 32'd1;
            if (uf) m_err = 1'b1;
        end
    endtask

    task automatic set_idle();
        id_valid = 0; id_rj = 0; id_rj_en = 0; id_rkd = 0; id_rkd_en = 0;
        id_dest = 0; id_gr_we = 0; id_issue = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        fwd_valid = 0; fwd_dest = 0; fwd_data_ok = 0; fwd_data = 0; fwd_cancel = 0;
        retire_we = 0; retire_dest = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        id_valid = 1; id_rj = 6; id_rj_en = 1;
        do_reset();
        set_idle();
        #1;
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_underflow); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready_go); end
        checks++; if (pend_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", pend_full); end
    endtask

    task automatic test_no_hazard();
        set_idle();
        id_valid = 1; id_rj = 3; id_rj_en = 1; rf_rdata1 = 32'h11;
        #1;
        checks++; if (rj_value !== 32'h11) begin failures++; $display("FAIL nohaz_value got=%0h exp=11", rj_value); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL nohaz_ready got=%0b exp=1", ready_go); end
    endtask

    task automatic test_priority();
        set_idle();
        id_valid = 1; id_rj = 5; id_rj_en = 1; rf_rdata1 = 32'hDEAD;
        fwd_valid = 3'b011; fwd_data_ok = 3'b011;
        fwd_dest[0 +: AW] = 5; fwd_dest[AW +: AW] = 5;
        fwd_data[0 +: DW] = 32'hA; fwd_data[DW +: DW] = 32'hB;
        #1;
        checks++; if (rj_value !== 32'hA) begin failures++; $display("FAIL prio_ch0 got=%0h exp=a", rj_value); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL prio_ready got=%0b exp=1", ready_go); end
        fwd_valid = 3'b010;
        #1;
        checks++; if (rj_value !== 32'hB) begin failures++; $display("FAIL prio_ch1 got=%0h exp=b", rj_value); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_idle();
        id_valid = 1; id_rkd = 7; id_rkd_en = 1;
        fwd_valid = 3'b001; fwd_dest[0 +: AW] = 7; fwd_data_ok = 3'b000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ready_go !== 1'b0) begin failures++; $display("FAIL loaduse_stall c=%0d got=%0b exp=0", c, ready_go); end
            tick();
        end
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL loaduse_cnt got=%0d exp=3", stall_cnt); end
        fwd_data_ok = 3'b001; fwd_data[0 +: DW] = 32'h55;
        #1;
        checks++; if (rkd_value !== 32'h55) begin failures++; $display("FAIL loaduse_value got=%0h exp=55", rkd_value); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL loaduse_ready got=%0b exp=1", ready_go); end
        tick();
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL loaduse_hold got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_r0();
        set_idle();
        id_valid = 1; id_rj = 0; id_rj_en = 1; rf_rdata1 = 32'h77;
        fwd_valid = 3'b001; fwd_dest[0 +: AW] = 0; fwd_data_ok = 3'b000; fwd_data[0 +: DW] = 32'h99;
        #1;
        checks++; if (rj_value !== 32'h0) begin failures++; $display("FAIL r0_value got=%0h exp=0", rj_value); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL r0_ready got=%0b exp=1", ready_go); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_idle();
        id_valid = 1; id_gr_we = 1; id_dest = 4; id_issue = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (pend_full !== 1'b0) begin failures++; $display("FAIL sat_fill c=%0d got=%0b exp=0", c, pend_full); end
            tick();
        end
        id_issue = 0;
        #1;
        checks++; if (pend_full !== 1'b1) begin failures++; $display("FAIL sat_full got=%0b exp=1", pend_full); end
        checks++; if (ready_go !== 1'b0) begin failures++; $display("FAIL sat_ready got=%0b exp=0", ready_go); end
        id_issue = 1; retire_we = 1; retire_dest = 4;
        tick();
        id_issue = 0; retire_we = 0;
        #1;
        checks++; if (pend_full !== 1'b1) begin failures++; $display("FAIL sat_issue_retire got=%0b exp=1", pend_full); end
        id_issue = 1;
        tick();
        id_issue = 0;
        #1;
        checks++; if (pend_full !== 1'b1) begin failures++; $display("FAIL sat_nowrap got=%0b exp=1", pend_full); end
        retire_we = 1;
        tick();
        retire_we = 0;
        #1;
        checks++; if (pend_full !== 1'b0) begin failures++; $display("FAIL sat_retire got=%0b exp=0", pend_full); end
        id_gr_we = 0; id_rj = 4; id_rj_en = 1;
        #1;
        checks++; if (ready_go !== 1'b0) begin failures++; $display("FAIL sat_pending_haz got=%0b exp=0", ready_go); end
    endtask

    task automatic test_cancel_underflow();
        do_reset();
        set_idle();
        id_valid = 1; id_gr_we = 1; id_dest = 9; id_issue = 1;
        tick();
        set_idle();
        id_valid = 1; id_rj = 9; id_rj_en = 1; rf_rdata1 = 32'h99;
        #1;
        checks++; if (ready_go !== 1'b0) begin failures++; $display("FAIL cancel_pending got=%0b exp=0", ready_go); end
        fwd_valid = 3'b001; fwd_dest[0 +: AW] = 9; fwd_cancel = 3'b001;
        tick();
        fwd_valid = 0; fwd_cancel = 0;
        #1;
        checks++; if (rj_value !== 32'h99) begin failures++; $display("FAIL cancel_value got=%0h exp=99", rj_value); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL cancel_ready got=%0b exp=1", ready_go); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL cancel_err got=%0b exp=0", err_underflow); end
        retire_we = 1; retire_dest = 9;
        tick();
        retire_we = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uflow_sticky c=%0d got=%0b exp=1", c, err_underflow); end
            tick();
        end
        do_reset();
        #1;
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uflow_clear got=%0b exp=0", err_underflow); end
    endtask

    task automatic test_reset_priority();
        set_idle();
        id_valid = 1; id_gr_we = 1; id_dest = 6; id_issue = 1;
        tick();
        tick();
        id_issue = 0;
        id_rkd = 6; id_rkd_en = 1;
        tick();
        tick();
        id_issue = 1; retire_we = 1; retire_dest = 3;
        do_reset();
        id_issue = 0; retire_we = 0;
        #1;
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rstprio_stall got=%0d exp=0", stall_cnt); end
        checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL rstprio_ready got=%0b exp=1", ready_go); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rstprio_err got=%0b exp=0", err_underflow); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ev1, ev2;
        bit eh1, eh2;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_idle();
            resetn    = ($urandom_range(0, 99) != 0);
            id_valid  = $urandom_range(0, 3) != 0;
            id_rj     = AW'($urandom_range(0, 7));
            id_rj_en  = $urandom_range(0, 3) != 0;
            id_rkd    = AW'($urandom_range(0, 7));
            id_rkd_en = $urandom_range(0, 1);
            id_dest   = AW'($urandom_range(0, 7));
            id_gr_we  = $urandom_range(0, 3) != 0;
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            for (int i = 0; i < NUM_FWD; i++) begin
                fwd_valid[i]        = $urandom_range(0, 1);
                fwd_dest[i*AW +: AW] = AW'($urandom_range(0, 7));
                fwd_data_ok[i]      = $urandom_range(0, 3) != 0;
                fwd_data[i*DW +: DW] = $urandom;
                fwd_cancel[i]       = $urandom_range(0, 7) == 0;
            end
            retire_we   = $urandom_range(0, 3) == 0;
            retire_dest = AW'($urandom_range(0, 7));
            id_issue    = id_valid && m_ready() && ($urandom_range(0, 1) == 1);
            #1;
            m_resolve(id_rj, id_rj_en, rf_rdata1, ev1, eh1);
            m_resolve(id_rkd, id_rkd_en, rf_rdata2, ev2, eh2);
            checks++; if (ready_go !== m_ready()) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, ready_go, m_ready()); end
            checks++; if (pend_full !== m_full()) begin failures++; $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, pend_full, m_full()); end
            if (!eh1) begin
                checks++; if (rj_value !== ev1) begin failures++; $display("FAIL rnd_rj c=%0d got=%0h exp=%0h", c, rj_value, ev1); end
            end
            if (!eh2) begin
                checks++; if (rkd_value !== ev2) begin failures++; $display("FAIL rnd_rkd c=%0d got=%0h exp=%0h", c, rkd_value, ev2); end
            end
            tick();
            checks++; if (stall_cnt !== m_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
            checks++; if (err_underflow !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, err_underflow, m_err); end
        end
        resetn = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        m_stall = 0;
        m_err   = 1'b0;
        resetn  = 1'b0;
        set_idle();
        #2;
        test_reset();
        test_no_hazard();
        test_priority();
        test_load_use();
        test_r0();
        test_saturation();
        test_cancel_underflow();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
